// File: rtl/otter_mem_arb_pkg.sv
// Shared types and constants for the OTTER imem/dmem memory arbiter.
package otter_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef enum logic {OWN_IMEM = 1'b0, OWN_DMEM = 1'b1} owner_t;

  // Wide enough to count 1..4, the legal memory latency range.
  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/otter_arb_pick2.sv
// Combinational two-way picker: req[0] = imem, req[1] = dmem; grant 1 selects dmem.
// With rr_mode set, a contended pick goes to the port that was not served last.
module otter_arb_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_mode,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = rr_mode ? ~last : 1'b1;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Serialises the OTTER fetch and data ports onto one single-ported fixed-latency RAM.
// Define OTTER_ARB_RR_EN for round-robin arbitration; otherwise dmem has fixed priority.
module otter_mem_arbiter
  import otter_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_strb,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  m_en,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_strb,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LATENCY);

`ifdef OTTER_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  arb_state_t            state_reg, state_next;
  logic [LAT_CNT_W-1:0]  cnt_reg, cnt_next;
  owner_t                owner_reg, owner_next;
  logic                  we_reg, we_next;
  logic                  m_en_reg, m_en_next;
  logic                  m_we_reg, m_we_next;
  logic [STRB_W-1:0]     m_strb_reg, m_strb_next;
  logic [ADDR_W-1:0]     m_addr_reg, m_addr_next;
  logic [DATA_W-1:0]     m_wdata_reg, m_wdata_next;
  logic [DATA_W-1:0]     i_rdata_reg, i_rdata_next;
  logic                  i_ack_reg, i_ack_next;
  logic [DATA_W-1:0]     d_rdata_reg, d_rdata_next;
  logic                  d_ack_reg, d_ack_next;
  logic                  busy_reg, busy_next;
  logic                  grant;

  // owner_reg doubles as the last-served port for round robin.
  otter_arb_pick2 u_pick (
    .req     ({d_req, i_req}),
    .last    (owner_reg),
    .rr_mode (RR_MODE),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      owner_reg   <= OWN_IMEM;
      we_reg      <= 1'b0;
      m_en_reg    <= 1'b0;
      m_we_reg    <= 1'b0;
      m_strb_reg  <= '0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      i_rdata_reg <= '0;
      i_ack_reg   <= 1'b0;
      d_rdata_reg <= '0;
      d_ack_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      owner_reg   <= owner_next;
      we_reg      <= we_next;
      m_en_reg    <= m_en_next;
      m_we_reg    <= m_we_next;
      m_strb_reg  <= m_strb_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
      i_rdata_reg <= i_rdata_next;
      i_ack_reg   <= i_ack_next;
      d_rdata_reg <= d_rdata_next;
      d_ack_reg   <= d_ack_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    owner_next   = owner_reg;
    we_next      = we_reg;
    m_en_next    = 1'b0;
    m_we_next    = 1'b0;
    m_strb_next  = '0;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    i_rdata_next = i_rdata_reg;
    i_ack_next   = 1'b0;
    d_rdata_next = d_rdata_reg;
    d_ack_next   = 1'b0;
    busy_next    = busy_reg;

    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          owner_next   = owner_t'(grant);
          we_next      = grant & d_we;
          m_en_next    = 1'b1;
          m_we_next    = grant & d_we;
          m_strb_next  = (grant && d_we) ? d_strb : '0;
          m_addr_next  = grant ? d_addr : i_addr;
          m_wdata_next = grant ? d_wdata : '0;
          busy_next    = 1'b1;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = LAT_CNT_W'(1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == LAT_LAST) begin
          cnt_next   = '0;
          state_next = RESP;
          if (owner_reg == OWN_DMEM) begin
            d_ack_next   = 1'b1;
            d_rdata_next = we_reg ? '0 : m_rdata;
          end else begin
            i_ack_next   = 1'b1;
            i_rdata_next = m_rdata;
          end
        end else begin
          cnt_next = cnt_reg + LAT_CNT_W'(1);
        end
      end
      RESP: begin
        // Read data is only meaningful alongside ack, so drop it back to zero.
        i_rdata_next = '0;
        d_rdata_next = '0;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_en    = m_en_reg;
  assign m_we    = m_we_reg;
  assign m_strb  = m_strb_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign i_rdata = i_rdata_reg;
  assign i_ack   = i_ack_reg;
  assign d_rdata = d_rdata_reg;
  assign d_ack   = d_ack_reg;
  assign busy    = busy_reg;
  assign owner   = owner_reg;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: directed cases then random traffic
// against a transaction-level model (arbitration rule, fixed timing, shadow memory).
module tb_otter_mem_arbiter;

  localparam int LAT  = 1;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_strb = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_en, m_we, busy, owner;
  logic [3:0]  m_strb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        i_req4 = 1'b0;
  logic [31:0] i_addr4 = '0;
  logic [31:0] i_rdata4;
  logic        i_ack4;
  logic        d_req4 = 1'b0;
  logic        d_we4 = 1'b0;
  logic [3:0]  d_strb4 = '0;
  logic [31:0] d_addr4 = '0;
  logic [31:0] d_wdata4 = '0;
  logic [31:0] d_rdata4;
  logic        d_ack4;
  logic        m_en4, m_we4, busy4, owner4;
  logic [3:0]  m_strb4;
  logic [31:0] m_addr4, m_wdata4, m_rdata4;

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_strb(d_strb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_strb(m_strb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy), .owner(owner)
  );

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT4)) dut4 (
    .clk(clk), .rst(rst),
    .i_req(i_req4), .i_addr(i_addr4), .i_rdata(i_rdata4), .i_ack(i_ack4),
    .d_req(d_req4), .d_we(d_we4), .d_strb(d_strb4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_rdata(d_rdata4), .d_ack(d_ack4),
    .m_en(m_en4), .m_we(m_we4), .m_strb(m_strb4), .m_addr(m_addr4), .m_wdata(m_wdata4),
    .m_rdata(m_rdata4), .busy(busy4), .owner(owner4)
  );

  // Initial RAM image; word 0x40 (byte address 0x100) holds a known instruction.
  function automatic logic [31:0] init_word(input int k);
    if (k == 'h40) return 32'h82F7B013;
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // RAM environment for dut: byte-strobed writes, reads appear LAT cycles after m_en.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [LAT];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
    end else if (m_en && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_strb[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (m_en && !m_we) ? mem[m_addr[9:2]] : $urandom;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign m_rdata = rd_pipe[LAT-1];

  logic [31:0] pipe4 [LAT4];
  always @(posedge clk) begin
    pipe4[0] <= (m_en4 && !m_we4) ? ((m_addr4 == 32'h3000) ? 32'h12345678 : 32'h0) : $urandom;
    for (int k = 1; k < LAT4; k++) pipe4[k] <= pipe4[k-1];
  end
  assign m_rdata4 = pipe4[LAT4-1];

  // Reference model state.
  logic [31:0] ref_mem [256];
  logic        last_own;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom);
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_strb  = 4'($urandom_range(1, 15));
  endtask

  // Called during an IDLE cycle with at least one request raised; runs one full
  // access and ends in the following IDLE cycle.
  task automatic do_txn(input bit scramble, input bit again);
    logic        win, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_strb;
    int          idx;
    if (i_req && d_req) begin
`ifdef OTTER_ARB_RR_EN
      win = ~last_own;
`else
      win = 1'b1;
`endif
    end else begin
      win = d_req;
    end
    e_we    = win & d_we;
    e_addr  = win ? d_addr : i_addr;
    e_strb  = e_we ? d_strb : 4'h0;
    e_wdata = d_wdata;
    idx     = int'(e_addr[9:2]);
    e_rdata = e_we ? 32'h0 : ref_mem[idx];
    if (e_we)
      for (int b = 0; b < 4; b++)
        if (e_strb[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
    last_own = win;

    step();
    chk1("issue_m_en", m_en, 1'b1);
    chk32("issue_m_addr", m_addr, e_addr);
    chk1("issue_m_we", m_we, e_we);
    chk32("issue_m_strb", 32'(m_strb), 32'(e_strb));
    if (e_we) chk32("issue_m_wdata", m_wdata, e_wdata);
    chk1("issue_owner", owner, win);
    chk1("issue_busy", busy, 1'b1);
    if (scramble) begin
      if (win) begin
        d_addr = $urandom; d_wdata = $urandom; d_strb = 4'($urandom); d_we = 1'($urandom);
        d_req  = ($urandom_range(0, 3) != 0);
      end else begin
        i_addr = $urandom;
        i_req  = ($urandom_range(0, 3) != 0);
      end
    end

    for (int c = 0; c < LAT; c++) begin
      step();
      chk1("wait_m_en", m_en, 1'b0);
      chk1("wait_i_ack", i_ack, 1'b0);
      chk1("wait_d_ack", d_ack, 1'b0);
      chk1("wait_busy", busy, 1'b1);
    end

    step();
    chk1("resp_i_ack", i_ack, ~win);
    chk1("resp_d_ack", d_ack, win);
    chk32("resp_rdata", win ? d_rdata : i_rdata, e_rdata);
    chk1("resp_m_en", m_en, 1'b0);
    chk1("resp_busy", busy, 1'b1);
    if (win) begin
      if (again) new_d(); else d_req = 1'b0;
    end else begin
      if (again) new_i(); else i_req = 1'b0;
    end

    step();
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_i_ack", i_ack, 1'b0);
    chk1("idle_d_ack", d_ack, 1'b0);
    chk1("idle_m_en", m_en, 1'b0);
    chk1("idle_owner", owner, win);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_m_en"}, m_en, 1'b0);
    chk1({tag, "_m_we"}, m_we, 1'b0);
    chk32({tag, "_m_strb"}, 32'(m_strb), 32'h0);
    chk32({tag, "_m_addr"}, m_addr, 32'h0);
    chk32({tag, "_m_wdata"}, m_wdata, 32'h0);
    chk32({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk32({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk1({tag, "_i_ack"}, i_ack, 1'b0);
    chk1({tag, "_d_ack"}, d_ack, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_owner"}, owner, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    last_own = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    mem_init = 1'b0;
    rst = 1'b0;
    step();

    // Fetch of 0x100 returns the preloaded instruction.
    i_addr = 32'h100; i_req = 1'b1;
    do_txn(1'b0, 1'b0);

    // Partial-strobe data write.
    d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_strb = 4'b0011; d_req = 1'b1;
    do_txn(1'b0, 1'b0);

    // Simultaneous requests, twice over.
    for (int r = 0; r < 2; r++) begin
      i_addr = 32'h40 + 32'(r); i_req = 1'b1;
      d_we = 1'b0; d_addr = 32'h2004; d_req = 1'b1;
      do_txn(1'b0, 1'b0);
      do_txn(1'b0, 1'b0);
    end

    // Both requesters held high across back-to-back accesses.
    new_i(); new_d();
    repeat (4) do_txn(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) if (i_req || d_req) do_txn(1'b0, 1'b0);

    // Long-latency read on the second instance.
    d_addr4 = 32'h3000; d_we4 = 1'b0; d_req4 = 1'b1;
    step();
    for (int c = 1; c <= 6; c++) begin
      chk1("lat4_m_en", m_en4, c == 1);
      chk1("lat4_busy", busy4, 1'b1);
      chk1("lat4_d_ack", d_ack4, c == 6);
      chk1("lat4_i_ack", i_ack4, 1'b0);
      if (c == 6) begin
        chk32("lat4_d_rdata", d_rdata4, 32'h12345678);
        d_req4 = 1'b0;
      end else begin
        step();
      end
    end
    step();
    chk1("lat4_idle_busy", busy4, 1'b0);
    chk1("lat4_idle_ack", d_ack4, 1'b0);

    // Random traffic.
    for (int it = 0; it < 200; it++) begin
      if (!i_req && $urandom_range(0, 2) == 0) new_i();
      if (!d_req && $urandom_range(0, 2) == 0) new_d();
      if (i_req || d_req) begin
        do_txn(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        step();
        chk1("quiet_m_en", m_en, 1'b0);
        chk1("quiet_busy", busy, 1'b0);
      end
    end
    for (int k = 0; k < 2; k++) if (i_req || d_req) do_txn(1'b0, 1'b0);

    // Reset in the middle of an access.
    i_addr = 32'h100; i_req = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    i_req = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (3) begin
      step();
      chk1("midrst_i_ack", i_ack, 1'b0);
      chk1("midrst_d_ack", d_ack, 1'b0);
    end
    rst = 1'b0;
    last_own = 1'b0;
    step();
    chk1("postrst_i_ack", i_ack, 1'b0);
    chk1("postrst_busy", busy, 1'b0);
    i_addr = 32'h100; i_req = 1'b1;
    do_txn(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
